// File: rtl/acc_forwarding_param.sv
// acc_forwarding_param: group accumulator that forwards each finished group's total into all of its pipeline slots
module acc_forwarding_param #(
  parameter int DATA_W  = 32,
  parameter int MAX_GRP = 16,
  parameter int LEN_W   = $clog2(MAX_GRP),
  parameter int BYP_W   = 1024,
  parameter bit SAT     = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_loc_sum,
  input  logic [LEN_W-1:0]  i_grp_len,
  input  logic [BYP_W-1:0]  i_byp,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_fwd,
  output logic              o_sat,
  output logic [BYP_W-1:0]  o_byp,
  output logic              o_abort
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] acc, acc_d, acc_next, clamp;
  logic [LEN_W-1:0]  cnt, cnt_d, len_q, len_d;
  logic              satf, satf_d, sat_next, ovf, fin, single, abort_q;
  logic [DATA_W:0]   wide;
  logic              v_q   [MAX_GRP];
  logic [DATA_W-1:0] sum_q [MAX_GRP];
  logic              fwd_q [MAX_GRP];
  logic              sat_q [MAX_GRP];
  logic [BYP_W-1:0]  byp_q [MAX_GRP];
  // One extra bit exposes signed overflow as a mismatch of the top two bits.
  assign wide     = {acc[DATA_W-1], acc} + {i_loc_sum[DATA_W-1], i_loc_sum};
  assign ovf      = wide[DATA_W] ^ wide[DATA_W-1];
  assign clamp    = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign acc_next = (SAT && ovf) ? clamp : wide[DATA_W-1:0];
  assign sat_next = satf | (SAT && ovf);
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    len_d   = len_q;
    satf_d  = satf;
    fin     = 1'b0;
    single  = 1'b0;
    if (i_en) begin
      if (state == IDLE) begin
        if (i_valid && i_grp_len == '0) single = 1'b1;
        else if (i_valid) begin
          state_d = ACC;
          len_d   = i_grp_len;
          acc_d   = i_loc_sum;
          cnt_d   = LEN_W'(1);
        end
      end else if (!i_valid || cnt == len_q) begin
        fin     = i_valid;
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        satf_d  = 1'b0;
      end else begin
        acc_d  = acc_next;
        cnt_d  = cnt + LEN_W'(1);
        satf_d = sat_next;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      satf    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      len_q   <= len_d;
      satf    <= satf_d;
      abort_q <= i_en && state == ACC && !i_valid;
    end
  end
  // At group end, slots 0..len_q hold exactly that group after the shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < MAX_GRP; k++) begin
        v_q[k]   <= 1'b0;
        sum_q[k] <= '0;
        fwd_q[k] <= 1'b0;
        sat_q[k] <= 1'b0;
        byp_q[k] <= '0;
      end
    end else if (i_en) begin
      v_q[0]   <= i_valid;
      sum_q[0] <= fin ? acc_next : i_loc_sum;
      fwd_q[0] <= fin | single;
      sat_q[0] <= fin & sat_next;
      byp_q[0] <= i_byp;
      for (int k = 1; k < MAX_GRP; k++) begin
        v_q[k]   <= v_q[k-1];
        sum_q[k] <= (fin && LEN_W'(k) <= len_q) ? acc_next : sum_q[k-1];
        fwd_q[k] <= (fin && LEN_W'(k) <= len_q) ? 1'b1 : fwd_q[k-1];
        sat_q[k] <= (fin && LEN_W'(k) <= len_q) ? sat_next : sat_q[k-1];
        byp_q[k] <= byp_q[k-1];
      end
    end
  end
  assign o_valid = v_q[MAX_GRP-1];
  assign o_sum   = sum_q[MAX_GRP-1];
  assign o_fwd   = fwd_q[MAX_GRP-1];
  assign o_sat   = sat_q[MAX_GRP-1] & fwd_q[MAX_GRP-1];
  assign o_byp   = byp_q[MAX_GRP-1];
  assign o_abort = abort_q;
endmodule

// File: doc/acc_forwarding_param.md
Name: acc_forwarding_param

Overview:
- Parametrised successor to the fixed 12-deep group accumulator. Accumulates signed per-chunk local sums over a group of 1..MAX_GRP consecutive valid beats.
- On the last beat of a group, forwards the group total back into every pipeline slot holding a member of that group. Every member therefore exits with the global sum.
- Carries an opaque sideband word (mode, input vector, partial-sum bypasses) through the same fixed-latency pipeline.
- Adds three behaviours: group length latched per group, abort on mid-group bubble, and optional saturation with per-entry flags.

Parameters:
- DATA_W, 32: width of the signed local and global sums.
- MAX_GRP, 16: maximum chunks per group. Also the pipeline depth and latency; must be ≥2.
- LEN_W, $clog2(MAX_GRP): width of i_grp_len.
- BYP_W, 1024: sideband width carried alongside each beat.
- SAT, 1: 1 = saturate accumulation at signed min/max; 0 = two's-complement wrap.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_en, input, 1: global advance. When 0, all state and pipelines hold.
- i_valid, input, 1: local-sum beat valid.
- i_loc_sum, input, DATA_W: signed local sum of this chunk.
- i_grp_len, input, LEN_W: group chunks minus 1. Sampled only on a group's first beat.
- i_byp, input, BYP_W: sideband, delayed unchanged.
- o_valid, output, 1: delayed i_valid.
- o_sum, output, DATA_W: global sum for completed-group members; otherwise the original local sum.
- o_fwd, output, 1: entry was overwritten with a group total.
- o_sat, output, 1: forwarded total saturated (SAT=1 only).
- o_byp, output, BYP_W: delayed i_byp.
- o_abort, output, 1: one-cycle pulse, the cycle after a group is aborted.

Behaviour:
- Reset (async, i_rst=1):
  - All pipeline stages clear: valid, sum, fwd, sat, byp = 0.
  - FSM goes to IDLE; accumulator, counter and latched length clear; o_abort=0.
  - All outputs read 0 immediately.
- Pipeline:
  - MAX_GRP stages, index 0..MAX_GRP-1. Each enabled cycle, stage0 takes the input beat and stage k takes stage k-1.
  - Beats with i_valid=0 still enter as bubbles.
  - Latency is exactly MAX_GRP enabled cycles, input to outputs.
- FSM IDLE, on enabled i_valid=1:
  - len=i_grp_len=0: single group. Stage0 gets sum=i_loc_sum, fwd=1.
  - len>0: latch len_q=len, set acc=i_loc_sum, cnt=1, go to ACC. Stage0 gets the local sum, fwd=0.
- FSM ACC, on enabled i_valid=1:
  - Compute acc_next=acc+i_loc_sum, saturated per SAT; track a sticky sat flag.
  - If cnt==len_q (end of group): write acc_next, fwd=1 and the sat flag into the new stage0 and into shifted stages 1..len_q. This overwrites the len_q earlier members. Then clear acc, cnt and sat, and return to IDLE.
  - Otherwise: acc=acc_next, cnt++.
  - i_grp_len is ignored while in ACC.
- FSM ACC, on enabled i_valid=0 (abort):
  - Go to IDLE; clear acc, cnt and sat; pulse o_abort next cycle.
  - Members already in the pipe keep their local sums with fwd=0.
- i_en=0: no state change, no abort detection, o_abort low.
- A group can start in IDLE on the cycle right after an end of group. There are no dead cycles.
- Stages 0..len_q hold exactly the current group at its end. Stages beyond len_q are never modified.
- Arithmetic:
  - Signed DATA_W; saturation limits are 2^(DATA_W-1)-1 and -2^(DATA_W-1).
  - Overflow is detected per add. Once saturated, later adds still saturate from the clamped value.
- o_sat=0 whenever SAT=0 or fwd=0.

Test Plan:
- Reset mid-group: assert i_rst during the 2nd beat of a len=3 group → outputs 0 at once. After release, a new len=0 beat 7 exits MAX_GRP cycles later with sum=7, fwd=1.
- Group of 4: i_grp_len=3, sums 1,2,3,4 on consecutive cycles → four output beats, each sum=10, fwd=1, o_byp matching the respective inputs.
- Length changed mid-group: i_grp_len=2 on beat1, then 0 on beats 2–3, sums 5,5,5 → all three outputs are 15. The next beat, sum 9 with len=0, outputs 9.
- Abort: len=3, sums 1,1, then i_valid=0 → o_abort pulses once; outputs are 1,1 with fwd=0, then a bubble.
- Saturation, SAT=1, DATA_W=32: len=1, sums 0x7FFFFFF0, 0x20 → both outputs 0x7FFFFFFF, o_sat=1. With SAT=0 the outputs are 0x80000010, o_sat=0.
- Stall and back-to-back: len=1 groups {2,3} then {4,4}, with i_en=0 for 3 cycles between beats → outputs 5,5,8,8, and total latency equals MAX_GRP enabled cycles.
